// File: rtl/sfp_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sfp_pkg                                                                    |
// | Lane-mode encodings and lane geometry/saturation helpers for the SFP stage.|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package sfp_pkg;

  localparam logic [1:0] LM_1X = 2'd0;
  localparam logic [1:0] LM_2X = 2'd1;
  localparam logic [1:0] LM_4X = 2'd2;

  // Reserved encoding 3 behaves as a single full-width lane.
  function automatic int lane_count(input logic [1:0] mode);
    case (mode)
      LM_2X:   return 2;
      LM_4X:   return 4;
      default: return 1;
    endcase
  endfunction

  function automatic int lane_width(input logic [1:0] mode, input int psum_bw);
    return psum_bw / lane_count(mode);
  endfunction

  // Only the low lw bits of these limits are meaningful.
  function automatic logic [63:0] sat_max(input int lw);
    return (64'd1 << (lw - 1)) - 64'd1;
  endfunction

  function automatic logic [63:0] sat_min(input int lw);
    return ~sat_max(lw);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sfp_lane_add.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sfp_lane_add                                                               |
// | Combinational sub-word lane adder with per-lane wrap or saturation.        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module sfp_lane_add
  import sfp_pkg::*;
#(
  parameter int PSUM_BW = 24
) (
  input  logic [PSUM_BW-1:0] a,
  input  logic [PSUM_BW-1:0] b,
  input  logic [1:0]         mode,
  input  logic               sat_en,
  output logic [PSUM_BW-1:0] sum,
  output logic               ovf
);

  // Each lane geometry gets its own carry-isolated adder bank; mode picks one.
  for (genvar m = 0; m < 3; m++) begin : g_mode
    localparam int c_lw = lane_width(2'(m), PSUM_BW);
    localparam int c_nl = PSUM_BW / c_lw;
    localparam logic [63:0] c_max = sat_max(c_lw);
    localparam logic [63:0] c_min = sat_min(c_lw);

    logic [PSUM_BW-1:0] w_res;
    logic [c_nl-1:0]    w_ovf;

    for (genvar i = 0; i < c_nl; i++) begin : g_lane
      logic [c_lw-1:0] w_a;
      logic [c_lw-1:0] w_b;
      logic [c_lw-1:0] w_s;
      logic            w_o;

      assign w_a = a[i*c_lw +: c_lw];
      assign w_b = b[i*c_lw +: c_lw];
      assign w_s = w_a + w_b;
      assign w_o = (w_a[c_lw-1] == w_b[c_lw-1]) && (w_s[c_lw-1] != w_a[c_lw-1]);
      assign w_ovf[i] = w_o;
      assign w_res[i*c_lw +: c_lw] = (w_o && sat_en)
                                   ? (w_a[c_lw-1] ? c_min[c_lw-1:0] : c_max[c_lw-1:0])
                                   : w_s;
    end
  end

  always_comb begin
    sum = g_mode[0].w_res;
    ovf = |g_mode[0].w_ovf;
    case (mode)
      LM_2X: begin
        sum = g_mode[1].w_res;
        ovf = |g_mode[1].w_ovf;
      end
      LM_4X: begin
        sum = g_mode[2].w_res;
        ovf = |g_mode[2].w_ovf;
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/sfp_lane_accum.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sfp_lane_accum                                                             |
// | Multi-entry lane accumulator with sticky overflow and registered ReLU read.|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module sfp_lane_accum
  import sfp_pkg::*;
#(
  parameter int COL     = 8,
  parameter int PSUM_BW = 24,
  parameter int DEPTH   = 16,
  parameter int AW      = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [PSUM_BW*COL-1:0] in_psum,
  input  logic [COL-1:0]         valid_in,
  input  logic [AW-1:0]          wr_addr,
  input  logic                   acc_first,
  input  logic [1:0]             lane_mode,
  input  logic                   sat_en,
  input  logic                   relu_en,
  input  logic                   rd_en,
  input  logic [AW-1:0]          rd_addr,
  output logic [PSUM_BW*COL-1:0] out_accum,
  output logic [COL-1:0]         wr_ofifo,
  output logic                   o_valid,
  output logic [COL-1:0]         ovf_flag,
  input  logic                   ovf_clr
);

  localparam int c_lw2 = lane_width(LM_2X, PSUM_BW);
  localparam int c_lw4 = lane_width(LM_4X, PSUM_BW);

  logic w_wr_ok;
  logic w_rd_ok;

  assign w_wr_ok = int'(wr_addr) < DEPTH;
  assign w_rd_ok = int'(rd_addr) < DEPTH;

  for (genvar k = 0; k < COL; k++) begin : g_col
    logic [PSUM_BW-1:0] r_entry [DEPTH];
    logic [PSUM_BW-1:0] w_in;
    logic [PSUM_BW-1:0] w_cur;
    logic [PSUM_BW-1:0] w_sum;
    logic [PSUM_BW-1:0] w_rd;
    logic [PSUM_BW-1:0] w_relu;
    logic [PSUM_BW-1:0] r_out;
    logic               w_ovf;
    logic               r_ovf;

    assign w_in  = in_psum[k*PSUM_BW +: PSUM_BW];
    assign w_cur = w_wr_ok ? r_entry[wr_addr] : '0;
    assign w_rd  = w_rd_ok ? r_entry[rd_addr] : '0;

    sfp_lane_add #(
      .PSUM_BW (PSUM_BW)
    ) u_add (
      .a      (w_cur),
      .b      (w_in),
      .mode   (lane_mode),
      .sat_en (sat_en),
      .sum    (w_sum),
      .ovf    (w_ovf)
    );

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        for (int d = 0; d < DEPTH; d++) begin
          r_entry[d] <= '0;
        end
      end else if (valid_in[k] && w_wr_ok) begin
        r_entry[wr_addr] <= acc_first ? w_in : w_sum;
      end
    end

    // A fresh overflow outranks a same-cycle clear.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_ovf <= 1'b0;
      end else if (valid_in[k] && w_wr_ok && !acc_first && w_ovf) begin
        r_ovf <= 1'b1;
      end else if (ovf_clr) begin
        r_ovf <= 1'b0;
      end
    end

    always_comb begin
      w_relu = w_rd;
      if (relu_en) begin
        case (lane_mode)
          LM_2X: begin
            for (int i = 0; i < 2; i++) begin
              if (w_rd[i*c_lw2 + c_lw2 - 1]) w_relu[i*c_lw2 +: c_lw2] = '0;
            end
          end
          LM_4X: begin
            for (int i = 0; i < 4; i++) begin
              if (w_rd[i*c_lw4 + c_lw4 - 1]) w_relu[i*c_lw4 +: c_lw4] = '0;
            end
          end
          default: begin
            if (w_rd[PSUM_BW-1]) w_relu = '0;
          end
        endcase
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_out <= '0;
      end else if (rd_en) begin
        r_out <= w_relu;
      end
    end

    assign out_accum[k*PSUM_BW +: PSUM_BW] = r_out;
    assign ovf_flag[k] = r_ovf;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ofifo <= '0;
      o_valid  <= 1'b0;
    end else begin
      wr_ofifo <= {COL{rd_en}};
      o_valid  <= rd_en;
    end
  end

endmodule
`default_nettype wire
